// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared prescaler and period
// counter, edge/center-aligned counting and double-buffered period/duty
// updates that take effect only at period boundaries.
// Optional build macro PWM_POLARITY_EN adds a per-channel, double-buffered
// output polarity; when it is undefined the outputs are active-high and idle low.
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic                      center_mode,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      load,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]       polarity,
`endif
    output logic                      load_pending,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       pwm_out
);

    logic [PRESC_W-1:0]        presc_cnt;
    logic [WIDTH-1:0]          counter;
    logic                      count_down;
    logic [WIDTH-1:0]          period_shadow;
    logic [WIDTH-1:0]          period_active;
    logic [CHANNELS*WIDTH-1:0] duty_shadow;
    logic [CHANNELS*WIDTH-1:0] duty_active;

    logic                      tick;
    logic                      boundary;
    logic                      transfer;
    logic [WIDTH-1:0]          count_next;
    logic                      down_next;
    logic [CHANNELS-1:0]       compare;
    logic [CHANNELS-1:0]       pol_run;
    logic [CHANNELS-1:0]       pol_idle;

`ifdef PWM_POLARITY_EN
    logic [CHANNELS-1:0]       pol_shadow;
    logic [CHANNELS-1:0]       pol_active;

    // Idle level follows the polarity that is (or is just becoming) active.
    assign pol_run  = pol_active;
    assign pol_idle = transfer ? pol_shadow : pol_active;
`else
    assign pol_run  = '0;
    assign pol_idle = '0;
`endif

    // A prescale lowered below the running count still ticks on the next clock
    // instead of waiting for the prescaler to wrap.
    assign tick     = enable && (presc_cnt >= prescale);
    assign boundary = tick && (count_next == '0);
    assign transfer = load_pending && (boundary || !enable);

    // Next counter value and direction for the coming tick.
    always_comb begin
        count_next = counter;
        down_next  = count_down;
        if (!center_mode) begin
            down_next  = 1'b0;
            count_next = (counter >= period_active) ? '0 : counter + 1'b1;
        end else if (period_active == '0) begin
            count_next = '0;
            down_next  = 1'b0;
        end else if (count_down) begin
            count_next = counter - 1'b1;
            down_next  = 1'b1;
        end else if (counter >= period_active) begin
            count_next = counter - 1'b1;
            down_next  = 1'b1;
        end else begin
            count_next = counter + 1'b1;
        end
        // Reaching zero always turns the count back upwards.
        if (count_next == '0) begin
            down_next = 1'b0;
        end
    end

    // Per-channel compare of the live counter against the active duty.
    always_comb begin
        compare = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            compare[i] = counter < duty_active[i*WIDTH +: WIDTH];
        end
    end

    // Prescaler, period counter, boundary pulse and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_cnt    <= '0;
            counter      <= '0;
            count_down   <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= '0;
        end else if (!enable) begin
            presc_cnt    <= '0;
            counter      <= '0;
            count_down   <= 1'b0;
            period_start <= 1'b0;
            pwm_out      <= pol_idle;
        end else begin
            pwm_out      <= compare ^ pol_run;
            period_start <= boundary;
            presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                counter    <= count_next;
                count_down <= down_next;
            end else if (!center_mode) begin
                count_down <= 1'b0;
            end
        end
    end

    // Shadow capture on load; shadow-to-active transfer at a boundary or while stopped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_shadow <= '0;
            period_active <= '0;
            duty_shadow   <= '0;
            duty_active   <= '0;
            load_pending  <= 1'b0;
`ifdef PWM_POLARITY_EN
            pol_shadow    <= '0;
            pol_active    <= '0;
`endif
        end else begin
            if (transfer) begin
                period_active <= period_shadow;
                duty_active   <= duty_shadow;
`ifdef PWM_POLARITY_EN
                pol_active    <= pol_shadow;
`endif
            end
            if (load) begin
                period_shadow <= period_in;
                duty_shadow   <= duty_in;
`ifdef PWM_POLARITY_EN
                pol_shadow    <= polarity;
`endif
            end
            if (load) begin
                load_pending <= 1'b1;
            end else if (transfer) begin
                load_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: directed scenarios followed by randomized stimulus,
// checked through an expected-output queue against a period/phase model.
`timescale 1ns/1ps
module tb_pwm_multi;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 8;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      enable = 1'b0;
    logic [PRESC_W-1:0]        prescale = '0;
    logic                      center_mode = 1'b0;
    logic [WIDTH-1:0]          period_in = '0;
    logic [CHANNELS*WIDTH-1:0] duty_in = '0;
    logic                      load = 1'b0;
    logic                      load_pending;
    logic                      period_start;
    logic [CHANNELS-1:0]       pwm_out;
`ifdef PWM_POLARITY_EN
    logic [CHANNELS-1:0]       polarity = '0;
`endif

    always #5 clock = ~clock;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRESC_W(PRESC_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .prescale     (prescale),
        .center_mode  (center_mode),
        .period_in    (period_in),
        .duty_in      (duty_in),
        .load         (load),
`ifdef PWM_POLARITY_EN
        .polarity     (polarity),
`endif
        .load_pending (load_pending),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    typedef struct packed {
        logic [CHANNELS-1:0] pwm;
        logic                ps;
        logic                pend;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: position within the period as a tick index (phase).
    int                  m_presc, m_phase, m_cnt;
    bit                  m_cm, m_pend;
    int                  m_per_sh, m_per_act;
    int                  m_duty_sh[CHANNELS];
    int                  m_duty_act[CHANNELS];
    bit [CHANNELS-1:0]   m_pol_sh, m_pol_act;

    task automatic model_reset();
        m_presc = 0; m_phase = 0; m_cnt = 0; m_cm = 1'b0; m_pend = 1'b0;
        m_per_sh = 0; m_per_act = 0; m_pol_sh = '0; m_pol_act = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            m_duty_sh[i] = 0;
            m_duty_act[i] = 0;
        end
    endtask

    // Predict the DUT outputs after the coming clock edge from the current inputs.
    task automatic model_step();
        exp_t              e;
        bit                tick, bnd, xfer;
        int                len;
        bit [CHANNELS-1:0] cmp;
        e = '0;
        if (!enable) begin
            xfer = m_pend;
            m_presc = 0; m_phase = 0; m_cnt = 0;
            e.pwm = xfer ? m_pol_sh : m_pol_act;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cmp[i] = (m_cnt < m_duty_act[i]);
            e.pwm = cmp ^ m_pol_act;
            // A mode change keeps the counter value and continues upward from it.
            if (center_mode != m_cm) m_phase = m_cnt;
            tick = (m_presc == int'(prescale));
            m_presc = tick ? 0 : m_presc + 1;
            bnd = 1'b0;
            if (tick) begin
                len = center_mode ? 2 * m_per_act : m_per_act + 1;
                m_phase = (len == 0) ? 0 : (m_phase + 1) % len;
                bnd = (m_phase == 0);
            end
            m_cnt = (center_mode && m_phase > m_per_act) ? 2 * m_per_act - m_phase : m_phase;
            xfer = bnd && m_pend;
            e.ps = bnd;
        end
        m_cm = center_mode;
        if (xfer) begin
            m_per_act = m_per_sh;
            m_pol_act = m_pol_sh;
            for (int i = 0; i < CHANNELS; i++) m_duty_act[i] = m_duty_sh[i];
            m_pend = 1'b0;
        end
        if (load) begin
            m_per_sh = int'(period_in);
            for (int i = 0; i < CHANNELS; i++) m_duty_sh[i] = int'(duty_in[i*WIDTH +: WIDTH]);
`ifdef PWM_POLARITY_EN
            m_pol_sh = polarity;
`endif
            m_pend = 1'b1;
        end
        e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    // One clock: queue the expectation, let the edge pass, drop the load strobe.
    task automatic step();
        if (!reset) exp_q.push_back('0);
        else model_step();
        @(posedge clock);
        #2;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        model_reset();
        exp_q.push_back('0);
        run(n);
        reset = 1'b1;
    endtask

    task automatic set_load(input int per, input int d0, input int d1, input int d2, input int d3);
        period_in = WIDTH'(per);
        duty_in   = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
`ifdef PWM_POLARITY_EN
        polarity  = CHANNELS'($urandom);
`endif
        load = 1'b1;
    endtask

    task automatic random_load();
        int per;
        per = ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 10));
        period_in = WIDTH'(per);
        for (int i = 0; i < CHANNELS; i++) begin
            case ($urandom_range(0, 9))
                0:       duty_in[i*WIDTH +: WIDTH] = '0;
                1:       duty_in[i*WIDTH +: WIDTH] = '1;
                default: duty_in[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 12));
            endcase
        end
`ifdef PWM_POLARITY_EN
        polarity = CHANNELS'($urandom);
`endif
        load = 1'b1;
    endtask

    // Monitor: compares every clock (and at reset assertion) against the queue.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clock or negedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pwm_out, period_start, load_pending};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t pwm_out got=%b want=%b period_start got=%b want=%b load_pending got=%b want=%b",
                             $time, got.pwm, e.pwm, got.ps, e.ps, got.pend, e.pend);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog t=%0t total=%0d bad=%0d", $time, total, bad);
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        do_reset(3);

        // Edge mode, prescale 0, period 9, duties {0,3,9,10}.
        enable = 1'b1; prescale = '0; center_mode = 1'b0;
        set_load(9, 0, 3, 9, 10);
        run(35);
        // Mid-period duty change on ch0 2 -> 7.
        set_load(9, 2, 3, 9, 10);
        run(14);
        set_load(9, 7, 3, 9, 10);
        run(25);
        // Load exactly on a boundary cycle while an earlier load is pending.
        set_load(5, 1, 2, 3, 4);
        run(3);
        while (dut.counter != 8'd9 && total < 10000) step();
        set_load(7, 6, 5, 4, 3);
        run(30);

        // Center mode, prescale 1, period 4, ch0 duty 2.
        enable = 1'b0; prescale = 8'd1; center_mode = 1'b1;
        set_load(4, 2, 0, 4, 5);
        run(2);
        enable = 1'b1;
        run(50);

        // Reset mid-period, then restart with active period 0.
        do_reset(2);
        enable = 1'b1; prescale = 8'd2; center_mode = 1'b0;
        run(12);

        // Disable with a load pending, then re-enable.
        set_load(6, 3, 7, 0, 2);
        run(2);
        enable = 1'b0;
        run(3);
        enable = 1'b1; prescale = '0;
        run(20);

        // Randomized operation.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset(2);
            if (!enable) begin
                if ($urandom_range(0, 3) == 0) enable = 1'b1;
            end else if ($urandom_range(0, 79) == 0) begin
                enable = 1'b0;
                prescale = PRESC_W'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 49) == 0) center_mode = ~center_mode;
            if ($urandom_range(0, 7) == 0) random_load();
            step();
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
